decode_queue_ctrl: RTL and testbench
====================================

DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

Interface
REQ-001 SHALL provide `clk`, input, 1 bit: system clock; all state updates on the rising edge.
REQ-002 SHALL provide `rstn`, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL provide `fetch_valid`, input, 1 bit: the fetch stage offers an instruction.
REQ-004 SHALL provide `fetch_instr`, input, 32 bits: the offered instruction word.
REQ-005 SHALL provide `fetch_pc`, input, 32 bits: PC of the offered instruction.
REQ-006 SHALL provide `fetch_ready`, output, 1 bit: the queue accepts the offer this cycle.
REQ-007 SHALL provide `dec_valid`, output, 1 bit: the head instruction is presented to decode.
REQ-008 SHALL provide `dec_instr`, output, 32 bits: the head instruction word.
REQ-009 SHALL provide `dec_pc`, output, 32 bits: the head PC.
REQ-010 SHALL provide `dec_ready`, input, 1 bit: decode/rename can consume (low when ROB or RS is full).
REQ-011 SHALL provide `flush`, input, 1 bit: branch-mispredict squash.
REQ-012 SHALL provide `occupancy`, output, 3 bits: number of entries held, 0..4.
REQ-013 SHALL provide `stall_cnt`, output, 16 bits: count of cycles with `dec_valid` high and `dec_ready` low.

Function
REQ-014 SHALL hold a 4-entry circular FIFO of {instr, pc}, with 2-bit write and read pointers and a 3-bit count.
REQ-015 SHALL implement a two-state FSM: RUN and FLUSH.
REQ-016 SHALL push when `fetch_valid` && `fetch_ready`, writing the entry at wr_ptr, then wr_ptr+1 (mod 4).
REQ-017 SHALL pop when `dec_valid` && `dec_ready`, then rd_ptr+1 (mod 4).
REQ-018 SHALL, in RUN, drive `fetch_ready` = (count != 4), with no same-cycle pass-through when full.
REQ-019 SHALL, in RUN, drive `dec_valid` = (count != 0), and drive `dec_instr`/`dec_pc` combinationally from the rd_ptr entry.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop.
REQ-021 SHALL make push-to-`dec_valid` latency exactly one cycle.
REQ-022 SHALL, when `flush` is sampled high in any state:
- next cycle: count=0, wr_ptr=0, rd_ptr=0, state=FLUSH;
- a same-cycle push is discarded;
- a same-cycle pop is still counted as consumed by decode.
REQ-023 SHALL, in FLUSH, force `fetch_ready`=0 and `dec_valid`=0, and return to RUN after one cycle unless `flush` is high again.
REQ-024 SHALL hold `dec_instr`/`dec_pc` stable while `dec_valid` is high and `dec_ready` is low.
REQ-025 SHALL increment `stall_cnt` each stall cycle, saturating at 16'hFFFF, and SHALL NOT clear it on `flush`.
REQ-026 SHALL drive `occupancy` equal to the registered count.

Reset
REQ-027 SHALL, when `rstn` is sampled low, set state=RUN, pointers=0, count=0 and stall_cnt=0, with reset taking priority over `flush`.
REQ-028 SHALL, in the cycle after reset, drive `fetch_ready`=1, `dec_valid`=0, `dec_instr`=0, `dec_pc`=0 and `occupancy`=0.
REQ-029 SHALL zero the storage array on reset.

Configuration
REQ-030 SHALL, when DECQ_BYPASS_EN is defined, present `fetch_instr`/`fetch_pc` directly with `dec_valid`=1 if in RUN with count==0 and `fetch_valid`=1.
- In that case, with `dec_ready`=1 the instruction is consumed and not pushed.
- Otherwise it is pushed as normal.
REQ-031 SHALL, when DECQ_BYPASS_EN is undefined, never bypass, so latency is always per REQ-021.

Structure
REQ-032 SHALL place DECQ_DEPTH=4, DECQ_PTR_W=2, INSTR_W=32 and the RUN/FLUSH state enum in shared package decode_pkg.
REQ-033 SHALL implement storage as sub-module decq_storage: one write port, one asynchronous read port, synchronous clear.

Verification
REQ-034 SHALL cover reset then push: instr 0x00500093, pc 0x0 → `dec_valid`=1 next cycle with matching data; `occupancy`=1.
REQ-035 SHALL cover fill with `dec_ready`=0: after 4 pushes → `fetch_ready`=0, `occupancy`=4; `stall_cnt` increments each held cycle.
REQ-036 SHALL cover simultaneous push/pop at occupancy 2 → occupancy stays 2; order preserved across pointer wrap (PCs 0x0..0x18).
REQ-037 SHALL cover `flush` at occupancy 3 together with `fetch_valid` → next cycle `occupancy`=0, `dec_valid`=0, `fetch_ready`=0; RUN one cycle later; the flushed instruction never appears.
REQ-038 SHALL cover, with DECQ_BYPASS_EN, empty queue, `fetch_valid`=1, `dec_ready`=1 → same-cycle `dec_valid`=1 with `dec_instr`=`fetch_instr`; `occupancy` stays 0.
REQ-039 SHALL cover `stall_cnt` preloaded near saturation: stall 3 more cycles from 0xFFFE → holds 0xFFFF.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue: sizes, FSM states and entry layout.
package decode_pkg;

  localparam int unsigned DECQ_DEPTH = 4;
  localparam int unsigned DECQ_PTR_W = 2;
  localparam int unsigned DECQ_CNT_W = 3;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned STALL_W    = 16;
  localparam int unsigned ENTRY_W    = 2 * INSTR_W;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } decq_state_e;

  // One queue slot: instruction word plus its PC.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc;
  } decq_entry_t;

endpackage

// File: rtl/decq_storage.sv
// Decode queue storage: one write port, one asynchronous read port,
// synchronous active-low clear of every slot.
module decq_storage
  import decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  we_i,
  input  logic [DECQ_PTR_W-1:0] waddr_i,
  input  logic [ENTRY_W-1:0]    wdata_i,
  input  logic [DECQ_PTR_W-1:0] raddr_i,
  output logic [ENTRY_W-1:0]    rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DECQ_DEPTH];

  // Slot array: cleared on reset, written at waddr_i when enabled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Head read is combinational so decode sees a pushed entry one cycle later.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Decode queue controller: 4-entry FIFO between fetch and decode with a
// RUN/FLUSH state machine and a saturating decode-stall counter.
// Optional feature: define DECQ_BYPASS_EN to let an empty queue hand the
// fetch offer straight to decode in the same cycle.
module decode_queue_ctrl
  import decode_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fetch_valid,
  input  logic [INSTR_W-1:0]    fetch_instr,
  input  logic [INSTR_W-1:0]    fetch_pc,
  output logic                  fetch_ready,
  output logic                  dec_valid,
  output logic [INSTR_W-1:0]    dec_instr,
  output logic [INSTR_W-1:0]    dec_pc,
  input  logic                  dec_ready,
  input  logic                  flush,
  output logic [DECQ_CNT_W-1:0] occupancy,
  output logic [STALL_W-1:0]    stall_cnt
);

  decq_state_e           state_q;
  logic [DECQ_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DECQ_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DECQ_CNT_W-1:0] count_q, count_d;
  logic [STALL_W-1:0]    stall_q, stall_d;

  logic                  run_c;
  logic                  byp_c;
  logic                  q_valid_c;
  logic                  push_c;
  logic                  pop_c;
  logic                  we_c;
  decq_entry_t           head_c;
  decq_entry_t           wr_entry_c;
  logic [ENTRY_W-1:0]    rd_data_c;

  decq_storage u_storage (
    .clk     (clk),
    .rstn    (rstn),
    .we_i    (we_c),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_c),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_c)
  );

  // Handshake and head presentation; FLUSH masks both sides of the queue.
  always_comb begin
    run_c     = (state_q == RUN);
    byp_c     = 1'b0;
`ifdef DECQ_BYPASS_EN
    byp_c     = run_c && (count_q == '0) && fetch_valid;
`endif
    head_c    = rd_data_c;
    fetch_ready = run_c && (count_q != DECQ_CNT_W'(DECQ_DEPTH));
    q_valid_c = run_c && (count_q != '0);
    dec_valid = q_valid_c || byp_c;
    dec_instr = byp_c ? fetch_instr : head_c.instr;
    dec_pc    = byp_c ? fetch_pc    : head_c.pc;
    // A bypassed offer taken by decode never enters the queue.
    push_c    = fetch_valid && fetch_ready && !(byp_c && dec_ready);
    pop_c     = q_valid_c && dec_ready;
    // Flush discards any same-cycle push.
    we_c      = push_c && !flush;
    wr_entry_c.instr = fetch_instr;
    wr_entry_c.pc    = fetch_pc;
    occupancy = count_q;
    stall_cnt = stall_q;
  end

  // Next pointers, count and stall counter.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    stall_d  = stall_q;

    if (dec_valid && !dec_ready && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + DECQ_PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + DECQ_PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count_d = count_q + DECQ_CNT_W'(1);
        2'b01:   count_d = count_q - DECQ_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // RUN/FLUSH state machine; a flush holds FLUSH for at least one cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= RUN;
    end else if (flush) begin
      state_q <= FLUSH;
    end else begin
      state_q <= RUN;
    end
  end

  // Queue bookkeeping registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Self-checking bench for decode_queue_ctrl: directed scenarios plus random
// traffic, compared against a queue-based behavioural model.
module tb_decode_queue_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        dec_valid;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        flush;
  logic [2:0]  occupancy;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  decode_queue_ctrl dut (
    .clk         (clk),
    .rstn        (rstn),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .fetch_pc    (fetch_pc),
    .fetch_ready (fetch_ready),
    .dec_valid   (dec_valid),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_ready   (dec_ready),
    .flush       (flush),
    .occupancy   (occupancy),
    .stall_cnt   (stall_cnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: contents in arrival order, flush-state flag, stall count.
  logic [63:0] mq[$];
  logic        m_flush = 1'b0;
  logic [15:0] m_stall = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, compare outputs to the model, then advance the model.
  task automatic cycle(input logic rn, input logic fv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic dr, input logic fl);
    logic        byp, er, ev, push, pop;
    logic [63:0] ex;
    @(negedge clk);
    rstn = rn; fetch_valid = fv; fetch_instr = ins; fetch_pc = pc;
    dec_ready = dr; flush = fl;
    #1;
    byp = 1'b0;
`ifdef DECQ_BYPASS_EN
    byp = !m_flush && (mq.size() == 0) && fv;
`endif
    er = !m_flush && (mq.size() < 4);
    ev = byp || (!m_flush && (mq.size() != 0));
    ex = byp ? {ins, pc} : ((mq.size() != 0) ? mq[0] : 64'h0);
    check("fetch_ready", 32'(fetch_ready), 32'(er));
    check("dec_valid",   32'(dec_valid),   32'(ev));
    check("occupancy",   32'(occupancy),   32'(mq.size()));
    check("stall_cnt",   32'(stall_cnt),   32'(m_stall));
    if (ev) begin
      check("dec_instr", dec_instr, ex[63:32]);
      check("dec_pc",    dec_pc,    ex[31:0]);
    end
    if (!rn) begin
      mq.delete();
      m_flush = 1'b0;
      m_stall = 16'h0;
    end else begin
      if (ev && !dr && (m_stall != 16'hFFFF)) m_stall++;
      push = fv && er;
      pop  = ev && dr;
      if (fl) begin
        mq.delete();
        m_flush = 1'b1;
      end else begin
        m_flush = 1'b0;
        if (!(byp && pop)) begin
          if (pop)  void'(mq.pop_front());
          if (push) mq.push_back({ins, pc});
        end
      end
    end
  endtask

  task automatic idle(input logic dr);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, dr, 1'b0);
  endtask

  initial begin
    rstn = 1'b0; fetch_valid = 1'b0; fetch_instr = '0; fetch_pc = '0;
    dec_ready = 1'b0; flush = 1'b0;

    // Reset, with a flush asserted underneath to show reset wins.
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
    check("rst_dec_valid",   32'(dec_valid),   32'd0);
    check("rst_dec_instr",   dec_instr,        32'h0);
    check("rst_dec_pc",      dec_pc,           32'h0);
    check("rst_occupancy",   32'(occupancy),   32'd0);
    check("rst_stall_cnt",   32'(stall_cnt),   32'd0);

    // First push appears at decode one cycle later.
    cycle(1'b1, 1'b1, 32'h00500093, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("push_dec_valid", 32'(dec_valid), 32'd1);
    check("push_dec_instr", dec_instr,      32'h00500093);
    check("push_dec_pc",    dec_pc,         32'h0);
    check("push_occupancy", 32'(occupancy), 32'd1);
    idle(1'b1);
    idle(1'b1);

    // Fill to four with decode stalled; a fifth offer is refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, $urandom, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hBAD0BAD0, 32'hBAD, 1'b0, 1'b0);
    check("full_fetch_ready", 32'(fetch_ready), 32'd0);
    check("full_occupancy",   32'(occupancy),   32'd4);
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Simultaneous push/pop at occupancy 2 across pointer wrap.
    cycle(1'b1, 1'b1, 32'hA0000000, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hA0000001, 32'h4, 1'b0, 1'b0);
    for (int k = 2; k < 7; k++) begin
      cycle(1'b1, 1'b1, 32'hA0000000 + 32'(k), 32'(4 * k), 1'b1, 1'b0);
      check("pp_occupancy", 32'(occupancy), 32'd2);
    end
    idle(1'b0);
    check("pp_occ_hold", 32'(occupancy), 32'd2);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush at occupancy 3 together with a fetch offer.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 32'hC0DE0000 + 32'(i), 32'h200 + 32'(4 * i), 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEAD0000, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 32'hDEAD0000, 1'b1, 1'b0);
    check("fl_occupancy",   32'(occupancy),   32'd0);
    check("fl_dec_valid",   32'(dec_valid),   32'd0);
    check("fl_fetch_ready", 32'(fetch_ready), 32'd0);
    idle(1'b1);
    check("fl_run_ready",   32'(fetch_ready), 32'd1);
    check("fl_run_valid",   32'(dec_valid),   32'd0);
    idle(1'b1);

`ifdef DECQ_BYPASS_EN
    // Empty queue: offer goes straight to decode and is not stored.
    cycle(1'b1, 1'b1, 32'h12345678, 32'h40, 1'b1, 1'b0);
    check("byp_dec_valid", 32'(dec_valid), 32'd1);
    check("byp_dec_instr", dec_instr,      32'h12345678);
    idle(1'b1);
    check("byp_occupancy", 32'(occupancy), 32'd0);
`endif

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
            $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
    end

    // Stall counter saturation: hold a full queue until the counter tops out.
    idle(1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, $urandom, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 70000 && m_stall != 16'hFFFE; i++) idle(1'b0);
    idle(1'b0);
    check("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    check("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
    cycle(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(1'b0);
    check("sat_no_clear_on_flush", 32'(stall_cnt), 32'h0000FFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
